// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the fade controller and its channels.
//   DUTY_W     - default duty / PWM counter width
//   ch_state_e - per-channel fade FSM state
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ch_state_e;

endpackage

// File: rtl/fade_channel.sv
// fade_channel: one duty channel with an IDLE/RAMP fade FSM.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tick_i    - fade tick; moves duty one step while ramping
//   hit_i     - an accepted command addresses this channel
//   target_i  - command target, already clamped to the legal range
//   step_i    - command step; 0 means set immediately
//   duty_o    - registered duty
//   busy_o    - high while ramping
//   done_o    - one-cycle pulse when a ramp lands on its target
module fade_channel
    import pwm_pkg::*;
#(
    parameter int W = DUTY_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_i,
    input  logic         hit_i,
    input  logic [W-1:0] target_i,
    input  logic [W-1:0] step_i,
    output logic [W-1:0] duty_o,
    output logic         busy_o,
    output logic         done_o
);

    ch_state_e    state_q;
    logic [W-1:0] duty_q;
    logic [W-1:0] tgt_q;
    logic [W-1:0] step_q;
    logic         done_q;

    logic [W:0]   up_sum;
    logic [W:0]   dn_diff;
    logic         going_up;
    logic         reach;
    logic [W-1:0] duty_d;

    // The extra top bit catches carry on the way up and borrow on the way
    // down, so a step that passes the target clamps instead of wrapping.
    always_comb begin
        up_sum   = {1'b0, duty_q} + {1'b0, step_q};
        dn_diff  = {1'b0, duty_q} - {1'b0, step_q};
        going_up = (tgt_q > duty_q);
        if (going_up) begin
            reach = (up_sum >= {1'b0, tgt_q});
        end else begin
            reach = dn_diff[W] || (dn_diff[W-1:0] <= tgt_q);
        end
        if (reach) begin
            duty_d = tgt_q;
        end else if (going_up) begin
            duty_d = up_sum[W-1:0];
        end else begin
            duty_d = dn_diff[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A command takes priority over a tick landing in the same cycle.
            if (hit_i) begin
                if (step_i == '0) begin
                    duty_q  <= target_i;
                    state_q <= ST_IDLE;
                end else if (target_i == duty_q) begin
                    state_q <= ST_IDLE;
                end else begin
                    tgt_q   <= target_i;
                    step_q  <= step_i;
                    state_q <= ST_RAMP;
                end
            end else if (state_q == ST_RAMP && tick_i) begin
                duty_q <= duty_d;
                if (reach) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign duty_o = duty_q;
    assign busy_o = (state_q == ST_RAMP);
    assign done_o = done_q;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: multi-channel duty fader feeding one PWM per channel.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   cmd_valid  - command strobe; cmd_ready - accept (always high out of reset)
//   cmd_ch     - target channel; out-of-range indices are dropped
//   cmd_target - final duty (clamped to MAX_COUNT)
//   cmd_step   - duty change per fade tick, 0 = immediate set
//   duty_out   - channel c at [c*W +: W], registered
//   busy       - per-channel ramp in progress
//   done       - per-channel one-cycle ramp-complete pulse
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int COUNTER_WIDTH = DUTY_W,
    parameter int MAX_COUNT     = 255,
    parameter int NUM_CH        = 4,
    parameter int TICK_DIV      = 50000,
    localparam int W            = COUNTER_WIDTH,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [W-1:0]        cmd_target,
    input  logic [W-1:0]        cmd_step,
    output logic [NUM_CH*W-1:0] duty_out,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   done
);

    localparam int           CNT_W = $clog2(TICK_DIV);
    localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tick;
    logic              accept;
    logic              ch_ok;
    logic [W-1:0]      tgt_clamped;
    logic [NUM_CH-1:0] hit;

    // Free-running fade timebase; tick on the last count of each period.
    assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // No backpressure: every cycle out of reset accepts.
    assign cmd_ready   = ~rst;
    assign accept      = cmd_valid & cmd_ready;
    assign ch_ok       = (32'(cmd_ch) < NUM_CH);
    assign tgt_clamped = (cmd_target > MAX_W) ? MAX_W : cmd_target;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign hit[c] = accept & ch_ok & (cmd_ch == CH_W'(c));

        fade_channel #(
            .W(W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick_i   (tick),
            .hit_i    (hit[c]),
            .target_i (tgt_clamped),
            .step_i   (cmd_step),
            .duty_o   (duty_out[c*W +: W]),
            .busy_o   (busy[c]),
            .done_o   (done[c])
        );
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // dut: 4 channels, full 8-bit range
    logic        valid = 1'b0;
    logic        ready;
    logic [1:0]  ch = '0;
    logic [7:0]  tgt = '0;
    logic [7:0]  stp = '0;
    logic [31:0] duty;
    logic [3:0]  busy;
    logic [3:0]  done;

    // dut2: 3 channels (index 3 is illegal), MAX_COUNT = 200
    logic        valid2 = 1'b0;
    logic        ready2;
    logic [1:0]  ch2 = '0;
    logic [7:0]  tgt2 = '0;
    logic [7:0]  stp2 = '0;
    logic [23:0] duty2;
    logic [2:0]  busy2;
    logic [2:0]  done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl #(
        .COUNTER_WIDTH(8), .MAX_COUNT(255), .NUM_CH(4), .TICK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(valid), .cmd_ready(ready),
        .cmd_ch(ch), .cmd_target(tgt), .cmd_step(stp),
        .duty_out(duty), .busy(busy), .done(done)
    );

    pwm_fade_ctrl #(
        .COUNTER_WIDTH(8), .MAX_COUNT(200), .NUM_CH(3), .TICK_DIV(4)
    ) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(valid2), .cmd_ready(ready2),
        .cmd_ch(ch2), .cmd_target(tgt2), .cmd_step(stp2),
        .duty_out(duty2), .busy(busy2), .done(done2)
    );

    function automatic logic [7:0] d(input int c);
        return duty[c*8 +: 8];
    endfunction

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c, input logic [7:0] t, input logic [7:0] s);
        valid = 1'b1; ch = c; tgt = t; stp = s;
    endtask

    task automatic send2(input logic [1:0] c, input logic [7:0] t, input logic [7:0] s);
        valid2 = 1'b1; ch2 = c; tgt2 = t; stp2 = s;
    endtask

    task automatic idle();
        valid = 1'b0; valid2 = 1'b0;
    endtask

    // Leaves the bench in the first cycle after reset (tick counter = 0).
    task automatic do_reset();
        idle();
        rst = 1'b1;
        tk(); tk();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tk(); tk();
        checks++; if (duty !== 32'h0 || duty2 !== 24'h0) begin errors++; $display("FAIL reset_duty: got %h/%h want 0", duty, duty2); end
        checks++; if (busy !== 4'h0 || done !== 4'h0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", ready); end
        rst = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", ready); end
    endtask

    task automatic test_step_up();
        int exp_d [4] = '{3, 6, 9, 10};
        int pulses = 0;
        do_reset();
        send(0, 10, 3);
        tk(); idle();
        checks++; if (busy[0] !== 1'b1 || d(0) !== 8'd0) begin errors++; $display("FAIL up_start: busy=%b duty=%0d want 1/0", busy[0], d(0)); end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < ((i == 0) ? 3 : 4); k++) begin
                tk();
                if (done[0]) pulses++;
            end
            checks++; if (d(0) !== 8'(exp_d[i])) begin errors++; $display("FAIL up_duty[%0d]: got %0d want %0d", i, d(0), exp_d[i]); end
            checks++; if (done[0] !== (i == 3)) begin errors++; $display("FAIL up_done[%0d]: got %b want %b", i, done[0], (i == 3)); end
        end
        tk(); if (done[0]) pulses++;
        repeat (4) begin tk(); if (done[0]) pulses++; end
        checks++; if (pulses != 1 || busy[0] !== 1'b0 || d(0) !== 8'd10) begin errors++; $display("FAIL up_end: pulses=%0d busy=%b duty=%0d want 1/0/10", pulses, busy[0], d(0)); end
    endtask

    task automatic test_step_down();
        int exp_d [4] = '{136, 72, 8, 0};
        int pulses = 0;
        do_reset();
        send(1, 200, 0);
        tk();
        send(1, 0, 64);
        checks++; if (d(1) !== 8'd200 || busy[1] !== 1'b0) begin errors++; $display("FAIL down_preset: duty=%0d busy=%b want 200/0", d(1), busy[1]); end
        tk(); idle();
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL down_busy: got %b want 1", busy[1]); end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < ((i == 0) ? 2 : 4); k++) begin
                tk();
                if (done[1]) pulses++;
            end
            checks++; if (d(1) !== 8'(exp_d[i])) begin errors++; $display("FAIL down_duty[%0d]: got %0d want %0d", i, d(1), exp_d[i]); end
        end
        repeat (5) begin tk(); if (done[1]) pulses++; end
        checks++; if (pulses != 1 || d(1) !== 8'd0 || busy[1] !== 1'b0) begin errors++; $display("FAIL down_end: pulses=%0d duty=%0d busy=%b want 1/0/0", pulses, d(1), busy[1]); end
    endtask

    task automatic test_immediate_clamp();
        int dn = 0;
        do_reset();
        send(2, 255, 0);
        send2(2, 255, 0);
        tk(); idle();
        checks++; if (d(2) !== 8'd255) begin errors++; $display("FAIL imm_set: got %0d want 255", d(2)); end
        checks++; if (duty2[23:16] !== 8'd200) begin errors++; $display("FAIL imm_clamp: got %0d want 200", duty2[23:16]); end
        checks++; if (busy !== 4'h0 || busy2 !== 3'h0) begin errors++; $display("FAIL imm_busy: got %b/%b want 0", busy, busy2); end
        repeat (8) begin tk(); if (done != 0 || done2 != 0) dn++; end
        checks++; if (dn != 0 || d(2) !== 8'd255) begin errors++; $display("FAIL imm_no_done: done_cycles=%0d duty=%0d want 0/255", dn, d(2)); end
    endtask

    task automatic test_bad_channel();
        do_reset();
        send2(0, 50, 0);
        tk();
        send2(3, 99, 0);
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", ready2); end
        tk();
        send2(3, 99, 1);
        checks++; if (duty2 !== 24'h000032 || busy2 !== 3'h0) begin errors++; $display("FAIL bad_set: duty=%h busy=%b want 000032/0", duty2, busy2); end
        tk(); idle();
        repeat (8) tk();
        checks++; if (duty2 !== 24'h000032 || busy2 !== 3'h0 || done2 !== 3'h0) begin errors++; $display("FAIL bad_ramp: duty=%h busy=%b done=%b want 000032/0/0", duty2, busy2, done2); end
    endtask

    task automatic test_collision();
        int e0 [5] = '{5, 10, 15, 20, 25};
        int e1 [5] = '{20, 30, 40, 40, 40};
        int p0 = 0;
        int p1 = 0;
        do_reset();
        send(1, 40, 10); tk();        // cycle 1
        send(0, 40, 10); tk();        // cycle 2
        idle(); tk();                 // cycle 3: tick cycle
        send(0, 25, 5); tk();         // retarget ch0 on the tick
        idle();
        checks++; if (d(0) !== 8'd0 || d(1) !== 8'd10) begin errors++; $display("FAIL coll_skip: ch0=%0d ch1=%0d want 0/10", d(0), d(1)); end
        checks++; if (busy[1:0] !== 2'b11) begin errors++; $display("FAIL coll_busy: got %b want 11", busy[1:0]); end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                tk();
                if (done[0]) p0++;
                if (done[1]) p1++;
            end
            checks++; if (d(0) !== 8'(e0[i]) || d(1) !== 8'(e1[i])) begin errors++; $display("FAIL coll_duty[%0d]: ch0=%0d ch1=%0d want %0d/%0d", i, d(0), d(1), e0[i], e1[i]); end
        end
        repeat (4) begin tk(); if (done[0]) p0++; if (done[1]) p1++; end
        checks++; if (p0 != 1 || p1 != 1 || busy !== 4'h0) begin errors++; $display("FAIL coll_done: p0=%0d p1=%0d busy=%b want 1/1/0", p0, p1, busy); end
    endtask

    task automatic test_reset_mid_ramp();
        int dn = 0;
        do_reset();
        send(0, 100, 10); tk(); idle();
        tk(); tk(); tk();
        checks++; if (d(0) !== 8'd10 || busy[0] !== 1'b1) begin errors++; $display("FAIL mid_pre: duty=%0d busy=%b want 10/1", d(0), busy[0]); end
        tk();
        rst = 1'b1;
        tk();
        checks++; if (duty !== 32'h0 || busy !== 4'h0 || done !== 4'h0 || ready !== 1'b0) begin errors++; $display("FAIL mid_reset: duty=%h busy=%b done=%b ready=%b want 0", duty, busy, done, ready); end
        rst = 1'b0;
        send(1, 50, 7);
        tk(); idle();
        if (done != 0) dn++;
        tk(); if (done != 0) dn++;
        tk(); if (done != 0) dn++;
        checks++; if (d(1) !== 8'd0) begin errors++; $display("FAIL mid_early_tick: got %0d want 0", d(1)); end
        tk(); if (done != 0) dn++;
        checks++; if (d(1) !== 8'd7) begin errors++; $display("FAIL mid_first_tick: got %0d want 7", d(1)); end
        repeat (6) begin tk(); if (done[0]) dn++; end
        checks++; if (dn != 0 || d(0) !== 8'd0 || busy[0] !== 1'b0) begin errors++; $display("FAIL mid_abort: done_cycles=%0d duty0=%0d busy0=%b want 0/0/0", dn, d(0), busy[0]); end
    endtask

    task automatic test_back_to_back();
        int dn = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            send(2'(c), 8'(c + 1), 0);
            tk();
        end
        idle();
        checks++; if (duty !== 32'h04030201) begin errors++; $display("FAIL b2b_duty: got %h want 04030201", duty); end
        send(0, 1, 5);
        tk(); idle();
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL b2b_same_target_busy: got %b want 0", busy); end
        repeat (6) begin tk(); if (done != 0) dn++; end
        checks++; if (dn != 0 || duty !== 32'h04030201) begin errors++; $display("FAIL b2b_hold: done_cycles=%0d duty=%h want 0/04030201", dn, duty); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_step_down();
        test_immediate_clamp();
        test_bad_channel();
        test_collision();
        test_reset_mid_ramp();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
